// File: rtl/scratch_rom_arb.sv
// Purpose : N-channel SDRAM ROM read arbiter with a one-word tagged cache per channel.
// Latency : a hit shows ch_ok in the same cycle; a miss raises sdram_req one cycle later,
//           and ch_ok rises the cycle after data_rdy.
// Backpres: sdram_req is held with a stable sdram_addr until sdram_ack. Misses wait in
//           round-robin order. Nothing is issued while downloading is high.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   ch_cs, ch_addr    per-channel read strobe and word address (channel i at [i*AW +: AW])
//   ch_data, ch_ok    per-channel cached word (channel i at [i*DW +: DW]) and its hit flag
//   downloading       ROM download in progress: invalidates the caches and blocks requests
//   sdram_req/addr    read request to the SDRAM controller, held until sdram_ack
//   sdram_ack         controller accepted the request
//   data_rdy/read     returned read data
//   refresh_en        controller may refresh (arbiter idle and nothing to fetch)

module scratch_rom_arb #(
   parameter int CH = 4,
   parameter int AW = 22,
   parameter int DW = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CH-1:0]    ch_cs,
   input  logic [CH*AW-1:0] ch_addr,
   output logic [CH*DW-1:0] ch_data,
   output logic [CH-1:0]    ch_ok,
   input  logic             downloading,
   output logic             sdram_req,
   output logic [AW-1:0]    sdram_addr,
   input  logic             sdram_ack,
   input  logic             data_rdy,
   input  logic [DW-1:0]    data_read,
   output logic             refresh_en
);

   localparam int GW = (CH > 1) ? $clog2(CH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t        state;
   logic [GW-1:0] grant;
   logic [GW-1:0] ptr;
   logic [GW-1:0] ptr_next;
   logic [AW-1:0] cur_addr;
   logic          dl_seen;
   logic          busy;

   logic [AW-1:0] tag    [CH];
   logic [DW-1:0] data_q [CH];
   logic [CH-1:0] valid;

   logic [CH-1:0] hit;
   logic [CH-1:0] miss;
   logic          any_miss;
   logic          found;
   logic [GW-1:0] winner;
   logic [AW-1:0] win_addr;

   assign busy = (state != IDLE);

   // Hit/miss per channel. A channel that is being served is not counted
   // as missing, so it cannot be granted twice for the same fetch. Hits
   // are suppressed while a download rewrites the ROM contents.
   always_comb begin
      hit  = '0;
      miss = '0;
      for (int i = 0; i < CH; i++) begin
         hit[i]  = ch_cs[i] & valid[i] & ~downloading &
                   (ch_addr[i*AW +: AW] == tag[i]);
         miss[i] = ch_cs[i] & ~hit[i] & ~(busy & (grant == GW'(i)));
      end
   end

   assign any_miss = |miss;
   assign ch_ok    = hit;

   // Round-robin pick: the first missing channel at or above ptr, wrapping.
   // The outer loop runs over search distance, so the closest one wins.
   always_comb begin
      found    = 1'b0;
      winner   = ptr;
      win_addr = '0;
      for (int k = 0; k < CH; k++) begin
         for (int j = 0; j < CH; j++) begin
            if (!found && miss[j] && (j == ((int'(ptr) + k) % CH))) begin
               found    = 1'b1;
               winner   = GW'(j);
               win_addr = ch_addr[j*AW +: AW];
            end
         end
      end
   end

   // The channel after the one just served becomes the head of the search.
   // With CH=1 this is always 0.
   assign ptr_next = (grant == GW'(CH - 1)) ? '0 : grant + 1'b1;

   // Refresh is allowed only when the arbiter is idle. That means either
   // there is nothing to fetch, or a download is blocking fetches anyway.
   assign refresh_en = (state == IDLE) & (downloading | ~any_miss);

   always_comb begin
      ch_data = '0;
      for (int i = 0; i < CH; i++) begin
         ch_data[i*DW +: DW] = data_q[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= '0;
         ptr        <= '0;
         cur_addr   <= '0;
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         dl_seen    <= 1'b0;
         valid      <= '0;
         for (int i = 0; i < CH; i++) begin
            tag[i]    <= '0;
            data_q[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (!downloading && any_miss) begin
                  grant      <= winner;
                  cur_addr   <= win_addr;
                  sdram_addr <= win_addr;
                  sdram_req  <= 1'b1;
                  dl_seen    <= 1'b0;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (sdram_ack) begin
                  sdram_req <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (data_rdy) begin
                  // The fill goes under the address that was captured at
                  // grant time, not the channel's current address. A download
                  // seen at any point in the fetch leaves the entry invalid.
                  for (int i = 0; i < CH; i++) begin
                     if (grant == GW'(i)) begin
                        tag[i]    <= cur_addr;
                        data_q[i] <= data_read;
                        if (!downloading && !dl_seen) begin
                           valid[i] <= 1'b1;
                        end
                     end
                  end
                  ptr   <= ptr_next;
                  state <= IDLE;
               end
            end
            default: begin
               sdram_req <= 1'b0;
               state     <= IDLE;
            end
         endcase

         if (downloading && busy) begin
            dl_seen <= 1'b1;
         end

         // Placed last so it overrides any fill landing in the same cycle.
         if (downloading) begin
            valid <= '0;
         end
      end
   end

endmodule

// File: tb/tb_scratch_rom_arb.sv
`timescale 1ns/1ps
// Purpose : directed bench for scratch_rom_arb, with hand-computed expected values.
// Latency : inputs are driven 1 ns after posedge clk, and outputs are checked 1 ns later.
// Backpres: the bench plays the SDRAM controller, supplying ack and data_rdy by hand.

module tb_scratch_rom_arb;

   localparam int CH = 4;
   localparam int AW = 22;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [CH-1:0]    ch_cs;
   logic [CH*AW-1:0] ch_addr;
   logic [CH*DW-1:0] ch_data;
   logic [CH-1:0]    ch_ok;
   logic             downloading;
   logic             sdram_req;
   logic [AW-1:0]    sdram_addr;
   logic             sdram_ack;
   logic             data_rdy;
   logic [DW-1:0]    data_read;
   logic             refresh_en;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   scratch_rom_arb #(.CH(CH), .AW(AW), .DW(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ch_cs       (ch_cs),
      .ch_addr     (ch_addr),
      .ch_data     (ch_data),
      .ch_ok       (ch_ok),
      .downloading (downloading),
      .sdram_req   (sdram_req),
      .sdram_addr  (sdram_addr),
      .sdram_ack   (sdram_ack),
      .data_rdy    (data_rdy),
      .data_read   (data_read),
      .refresh_en  (refresh_en)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      ch_addr[i*AW +: AW] = a;
   endtask

   function automatic logic [DW-1:0] data_of(input int i);
      return ch_data[i*DW +: DW];
   endfunction

   task automatic wait_req(input logic [AW-1:0] exp_addr, input string tag);
      int n = 0;
      while (!sdram_req && n < 50) begin
         cyc();
         n++;
      end
      chk({tag, "_req"}, 64'(sdram_req), 64'd1);
      if (sdram_req) chk({tag, "_addr"}, 64'(sdram_addr), 64'(exp_addr));
   endtask

   task automatic do_ack(input string tag);
      sdram_ack = 1'b1;
      cyc();
      sdram_ack = 1'b0;
      settle();
      chk({tag, "_req_drop"}, 64'(sdram_req), 64'd0);
   endtask

   task automatic do_data(input logic [DW-1:0] dat);
      data_rdy  = 1'b1;
      data_read = dat;
      cyc();
      data_rdy  = 1'b0;
      data_read = '0;
      settle();
   endtask

   task automatic serve(input logic [AW-1:0] a, input logic [DW-1:0] dat, input string tag);
      wait_req(a, tag);
      do_ack(tag);
      cyc();
      do_data(dat);
   endtask

   task automatic reset_dut();
      rst_n       = 1'b0;
      ch_cs       = '0;
      downloading = 1'b0;
      sdram_ack   = 1'b0;
      data_rdy    = 1'b0;
      data_read   = '0;
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      ch_cs       = '0;
      ch_addr     = '0;
      downloading = 1'b0;
      sdram_ack   = 1'b0;
      data_rdy    = 1'b0;
      data_read   = '0;

      // ---- reset state
      repeat (3) cyc();
      chk("rst_req",     64'(sdram_req),  64'd0);
      chk("rst_ok",      64'(ch_ok),      64'd0);
      chk("rst_refresh", 64'(refresh_en), 64'd1);
      chk("rst_addr",    64'(sdram_addr), 64'd0);
      rst_n = 1'b1;
      repeat (5) cyc();
      chk("idle_req",     64'(sdram_req),  64'd0);
      chk("idle_refresh", 64'(refresh_en), 64'd1);

      // ---- single miss: ack in cycle 2, data in cycle 4, ok in cycle 5
      set_addr(0, 22'h000100);
      ch_cs = 4'b0001;
      settle();
      chk("t2_refresh_miss", 64'(refresh_en), 64'd0);
      chk("t2_ok_pre",       64'(ch_ok),      64'd0);
      cyc();
      chk("t2_req_c1",  64'(sdram_req),  64'd1);
      chk("t2_addr_c1", 64'(sdram_addr), 64'h100);
      cyc();
      sdram_ack = 1'b1;
      cyc();
      sdram_ack = 1'b0;
      settle();
      chk("t2_req_c3", 64'(sdram_req), 64'd0);
      cyc();
      data_rdy  = 1'b1;
      data_read = 32'hDEADBEEF;
      settle();
      chk("t2_ok_c4", 64'(ch_ok), 64'd0);
      cyc();
      data_rdy  = 1'b0;
      data_read = '0;
      settle();
      chk("t2_ok_c5",   64'(ch_ok),      64'b0001);
      chk("t2_data_c5", 64'(data_of(0)), 64'hDEADBEEF);
      ch_cs = '0;
      cyc();
      cyc();
      ch_cs = 4'b0001;
      settle();
      chk("t2_rehit_ok", 64'(ch_ok), 64'b0001);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t2_rehit_noreq", 64'(sdram_req), 64'd0);
      end

      // ---- four simultaneous misses, then round-robin wrap
      reset_dut();
      set_addr(0, 22'h10);
      set_addr(1, 22'h20);
      set_addr(2, 22'h30);
      set_addr(3, 22'h40);
      ch_cs = 4'b1111;
      settle();
      chk("t3_ok_pre", 64'(ch_ok), 64'd0);
      serve(22'h10, 32'hA000_0010, "t3_g0");
      serve(22'h20, 32'hA000_0020, "t3_g1");
      serve(22'h30, 32'hA000_0030, "t3_g2");
      serve(22'h40, 32'hA000_0040, "t3_g3");
      chk("t3_ok_all", 64'(ch_ok),      64'b1111);
      chk("t3_data0",  64'(data_of(0)), 64'hA000_0010);
      chk("t3_data1",  64'(data_of(1)), 64'hA000_0020);
      chk("t3_data2",  64'(data_of(2)), 64'hA000_0030);
      chk("t3_data3",  64'(data_of(3)), 64'hA000_0040);
      set_addr(0, 22'h11);
      set_addr(2, 22'h31);
      settle();
      chk("t3_ok_part", 64'(ch_ok), 64'b1010);
      serve(22'h11, 32'hB000_0011, "t3_rr0");
      serve(22'h31, 32'hB000_0031, "t3_rr2");
      chk("t3_ok_rr", 64'(ch_ok), 64'b1111);

      // ---- address change between ack and data
      ch_cs = 4'b0010;
      set_addr(1, 22'h50);
      wait_req(22'h50, "t4");
      do_ack("t4");
      set_addr(1, 22'h60);
      cyc();
      do_data(32'h5050_5050);
      chk("t4_ok_mismatch", 64'(ch_ok[1]), 64'd0);
      serve(22'h60, 32'h6060_6060, "t4_refetch");
      chk("t4_ok_after", 64'(ch_ok[1]),   64'd1);
      chk("t4_data1",    64'(data_of(1)), 64'h6060_6060);

      // ---- download while a fill is in flight
      ch_cs = 4'b1010;
      set_addr(3, 22'h44);
      wait_req(22'h44, "t5");
      do_ack("t5");
      cyc();
      downloading = 1'b1;
      data_rdy    = 1'b1;
      data_read   = 32'h4444_4444;
      settle();
      chk("t5_ok_dl", 64'(ch_ok), 64'd0);
      cyc();
      data_rdy  = 1'b0;
      data_read = '0;
      settle();
      chk("t5_ok_after_fill", 64'(ch_ok),      64'd0);
      chk("t5_refresh",       64'(refresh_en), 64'd1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t5_noreq_dl",   64'(sdram_req),  64'd0);
         chk("t5_refresh_dl", 64'(refresh_en), 64'd1);
      end
      downloading = 1'b0;
      settle();
      chk("t5_refresh_miss", 64'(refresh_en), 64'd0);
      serve(22'h60, 32'h6161_6161, "t5_re1");
      serve(22'h44, 32'h4545_4545, "t5_re3");
      chk("t5_ok_refetch", 64'(ch_ok),      64'b1010);
      chk("t5_data1",      64'(data_of(1)), 64'h6161_6161);
      chk("t5_data3",      64'(data_of(3)), 64'h4545_4545);

      // ---- asynchronous reset in REQ, late data_rdy ignored
      ch_cs = 4'b0001;
      set_addr(0, 22'h77);
      wait_req(22'h77, "t6");
      rst_n = 1'b0;
      #1;
      chk("t6_req_async", 64'(sdram_req), 64'd0);
      ch_cs = '0;
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      data_rdy  = 1'b1;
      data_read = 32'h7777_7777;
      cyc();
      data_rdy  = 1'b0;
      data_read = '0;
      set_addr(1, 22'h60);
      set_addr(2, 22'h31);
      set_addr(3, 22'h44);
      ch_cs = 4'b1111;
      settle();
      chk("t6_ok_cleared", 64'(ch_ok),      64'd0);
      chk("t6_refresh",    64'(refresh_en), 64'd0);
      chk("t6_data0",      64'(data_of(0)), 64'd0);
      ch_cs = '0;
      cyc();
      cyc();
      chk("t6_noreq", 64'(sdram_req), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/scratch_rom_arb.md
Name: scratch_rom_arb

Overview:
- N-channel SDRAM ROM read arbiter for the Scratch game top level; the parametrised successor to the single-requester SDRAM hookup.
- Each consumer channel (CPU, char, obj, sound) presents a word address and chip-select, and gets back a 32-bit word plus an ok flag.
- The block keeps a one-word tagged cache per channel and round-robins misses onto the single sdram_req/sdram_ack/data_rdy interface.
- It drives refresh_en when idle.

Parameters:
- CH, 4, number of requesting channels (1..8).
- AW, 22, SDRAM word address width.
- DW, 32, SDRAM data width.

Ports:
- clk  in  1  system clock (48 MHz).
- rst_n  in  1  asynchronous active-low reset.
- ch_cs  in  CH  per-channel read request; bit i belongs to channel i.
- ch_addr  in  CH*AW  packed addresses; channel i uses bits [i*AW +: AW].
- ch_data  out  CH*DW  packed cached words; channel i uses bits [i*DW +: DW].
- ch_ok  out  CH  channel i's data is valid for its current address.
- downloading  in  1  ROM download in progress; blocks requests and invalidates the caches.
- sdram_req  out  1  SDRAM read request.
- sdram_addr  out  AW  SDRAM read address.
- sdram_ack  in  1  controller accepted the request.
- data_rdy  in  1  data_read valid.
- data_read  in  DW  SDRAM read data.
- refresh_en  out  1  controller may refresh.

Behaviour:
Reset (rst_n low, asynchronous):
- sdram_req=0, sdram_addr=0, ch_data=0, all tags=0, all valid=0.
- Round-robin pointer=0, FSM=IDLE, refresh_en=1.
- Reset asserted mid-transaction aborts it; any late data_rdy after release is ignored because the FSM is in IDLE.

Per-channel hit logic (combinational):
- hit_i = ch_cs[i] & valid_i & (ch_addr_i == tag_i).
- ch_ok[i] = hit_i.
- miss_i = ch_cs[i] & ~hit_i & ~(busy & grant==i).

FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If downloading=0 and any miss: pick the winner by round-robin, searching from pointer upward and wrapping modulo CH.
  - Register grant=winner, cur_addr=ch_addr_winner, sdram_addr=ch_addr_winner, sdram_req=1. Go to REQ.
  - refresh_en=1 only when in IDLE with no miss, or with downloading=1.
- REQ:
  - Hold sdram_req=1 and sdram_addr stable until sdram_ack is sampled high.
  - Then sdram_req=0 on the next cycle and go to WAIT.
- WAIT:
  - On data_rdy: tag_grant=cur_addr, ch_data_grant=data_read, valid_grant=1, pointer=(grant+1) mod CH. Go to IDLE.
  - data_rdy is ignored in IDLE and REQ.

Latency:
- Miss in cycle 0 gives sdram_req high in cycle 1.
- With sdram_ack in cycle k and data_rdy in cycle m>k, ch_ok rises in cycle m+1.
- A hit gives ch_ok in the same cycle as cs/addr.

Boundary conditions:
- Address changes during a transaction: the data is stored under the captured cur_addr. ch_ok stays low on tag mismatch, and the new address is re-requested after returning to IDLE.
- ch_cs drops during a transaction: the transaction completes and the cache is filled.
- Simultaneous misses: exactly one grant per transaction. Every pending channel is served within CH transactions (no starvation).
- downloading rises:
  - All valid bits clear that cycle.
  - An in-flight transaction completes, but its fill is discarded (valid stays 0).
  - No new request is issued while downloading=1.
- CH=1: the pointer is constant 0.

Test Plan:
- Reset with rst_n=0 while clk runs -> sdram_req=0, ch_ok=0, refresh_en=1; release and hold ch_cs=0 -> no request.
- Ch0 cs=1, addr=0x000100; ack at +2, data_rdy with 0xDEADBEEF at +4 -> sdram_addr=0x000100; ch_ok[0] rises the cycle after data_rdy with ch_data0=0xDEADBEEF; re-presenting 0x000100 gives ch_ok=1 with no new sdram_req.
- Ch0..3 all miss simultaneously (addrs 0x10, 0x20, 0x30, 0x40) -> grant order 0, 1, 2, 3; then a ch0 and ch2 miss together -> ch0 first (pointer wrapped to 0 after ch3), then ch2.
- Ch1 addr changes from 0x50 to 0x60 between ack and data_rdy -> ch_ok[1] stays 0 after the fill; a second request is issued for 0x60, then ch_ok[1]=1.
- downloading=1 pulsed while in WAIT with data_rdy arriving -> all ch_ok=0, no sdram_req while downloading=1, refresh_en=1; after downloading=0 the misses are re-fetched.
- rst_n asserted in REQ -> sdram_req=0 immediately (asynchronous); a data_rdy after release leaves all ch_ok=0.
